// File: rtl/qpsk_carrier_modulator.sv
`default_nettype none
// ============================================================================
// qpsk_carrier_modulator: QPSK symbol intake (valid/ready, one-deep hold) and
// +/-1 mixing of the NCO cos/sin pair into a signed sample stream, 2-stage pipe.
// Optional differential quadrant encoding: define QPSK_DIFF_ENC_EN.
// Revision: 1.0
// ============================================================================
module qpsk_carrier_modulator #(
  parameter int DATA_WIDTH    = 16,
  parameter int SYMBOL_CYCLES = 2000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   sym_data,
  input  logic                         sym_valid,
  output logic                         sym_ready,
  input  logic [DATA_WIDTH-1:0]        sin_in,
  input  logic [DATA_WIDTH-1:0]        cos_in,
  output logic signed [DATA_WIDTH:0]   mod_out,
  output logic                         mod_valid,
  output logic                         sym_start,
  output logic                         busy
);

  localparam int                   MSB      = DATA_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(SYMBOL_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 hold_full;
  logic [1:0]           hold_data;
  logic [1:0]           cur_data;

  logic                 xfer;
  logic                 sym_end;
  logic                 load_cur;
  logic [1:0]           next_sym;
  logic [1:0]           next_tx;

  assign sym_ready = !hold_full;
  assign xfer      = sym_valid && sym_ready;
  assign sym_end   = (state == RUN) && (cnt == LAST_CNT);

  // A waiting hold symbol always wins; otherwise the incoming one bypasses hold.
  assign next_sym  = hold_full ? hold_data : sym_data;
  assign load_cur  = (state == IDLE) ? (xfer || hold_full)
                                     : (sym_end && (hold_full || xfer));

`ifdef QPSK_DIFF_ENC_EN
  logic [1:0] prev_quad;
  logic [1:0] tx_quad;

  // Gray dibit <-> quadrant index (00->0, 01->1, 11->2, 10->3) is self-inverse.
  function automatic logic [1:0] gray_swap(input logic [1:0] v);
    return {v[1], v[1] ^ v[0]};
  endfunction

  assign tx_quad = prev_quad + gray_swap(next_sym);
  assign next_tx = gray_swap(tx_quad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_quad <= 2'd0;
    end else if (load_cur) begin
      prev_quad <= tx_quad;
    end
  end
`else
  assign next_tx = next_sym;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_full <= 1'b0;
      hold_data <= 2'b00;
      cur_data  <= 2'b00;
    end else begin
      if (load_cur) begin
        cur_data <= next_tx;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (load_cur) begin
            state     <= RUN;
            hold_full <= 1'b0;
          end
        end
        RUN: begin
          if (sym_end) begin
            cnt       <= '0;
            hold_full <= 1'b0;
            if (!load_cur) begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (xfer) begin
              hold_full <= 1'b1;
              hold_data <= sym_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [DATA_WIDTH-1:0] cos_s;
  logic signed [DATA_WIDTH-1:0] sin_s;
  logic signed [DATA_WIDTH-1:0] i_term;
  logic signed [DATA_WIDTH-1:0] q_term;
  logic signed [DATA_WIDTH-1:0] i_s1;
  logic signed [DATA_WIDTH-1:0] q_s1;
  logic                         act_s1;
  logic                         start_s1;

  // Offset-binary to two's complement; negation by inversion keeps -(-2^(N-1)) in range.
  assign cos_s  = {~cos_in[MSB], cos_in[MSB-1:0]};
  assign sin_s  = {~sin_in[MSB], sin_in[MSB-1:0]};
  assign i_term = cur_data[1] ? ~cos_s : cos_s;
  assign q_term = cur_data[0] ? ~sin_s : sin_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_s1      <= '0;
      q_s1      <= '0;
      act_s1    <= 1'b0;
      start_s1  <= 1'b0;
      mod_out   <= '0;
      mod_valid <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      act_s1    <= (state == RUN);
      start_s1  <= (state == RUN) && (cnt == '0);
      i_s1      <= (state == RUN) ? i_term : '0;
      q_s1      <= (state == RUN) ? q_term : '0;
      mod_out   <= {i_s1[MSB], i_s1} + {q_s1[MSB], q_s1};
      mod_valid <= act_s1;
      sym_start <= start_s1;
    end
  end

  assign busy = (state == RUN) || act_s1 || mod_valid;

endmodule
`default_nettype wire
